vga_text_line_renderer: RTL
===========================

Name: vga_text_line_renderer

Overview:
- Parametrised glyph renderer: draws NUM_CHARS fixed-size characters from a shared glyph ROM as one horizontal text line in a VGA raster. It generalises the clock display to any character count, glyph size, origin and colour.
- Sits between vga timing generation (pixel x/y, de, hs, vs) and the DAC pins.
- Adds frame-synchronous code latching and timed per-slot blinking. Blinking replaces static blanking for adjust indication.

Parameters:
- NUM_CHARS, 8, character slots on the line
- CODE_W, 4, bits per character code
- NUM_GLYPHS, 11, valid codes 0..NUM_GLYPHS-1; higher codes render blank
- CHAR_W, 32, glyph width in pixels, multiple of 8
- CHAR_H, 64, glyph height in pixels
- X0, 64, left pixel column of slot 0
- Y0, 208, top pixel row of the line
- ROM_LAT, 2, clocks from rom_addr to valid rom_q, minimum 1
- BLINK_FRAMES, 15, frames per blink half-period, minimum 1
- RGB_W, 8, colour width
- FG, 8'hFF, foreground colour
- BG, 8'h00, in-box background colour

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- in_de  in  1  active-video flag from timing generator
- in_hs  in  1  hsync, active-low
- in_vs  in  1  vsync, active-low
- in_x  in  10  pixel column
- in_y  in  10  pixel row
- char_codes  in  NUM_CHARS*CODE_W  slot i code at bits [i*CODE_W +: CODE_W]; slot 0 leftmost
- blink_mask  in  NUM_CHARS  1 = slot i blinks
- rom_addr  out  ROM_AW  glyph ROM byte address; ROM_AW = CODE_W + clog2(CHAR_W*CHAR_H/8)
- rom_q  in  8  glyph ROM byte, MSB = leftmost pixel
- out_de  out  1  delayed in_de
- out_hs  out  1  delayed in_hs
- out_vs  out  1  delayed in_vs
- out_rgb  out  RGB_W  pixel colour

Behaviour:
- Reset values: out_de=0, out_hs=1, out_vs=1, out_rgb=0, rom_addr=0. Shadow codes = 0, shadow mask = 0, frame counter = 0, blink_phase = 0 (visible). All pipeline valid bits are cleared.
- Reset mid-frame: the pipeline flushes. Outputs hold their reset values until LAT clocks of fresh input have passed.
- Latency: LAT = ROM_LAT + 2 clocks, fixed. out_de, out_hs, out_vs and out_rgb for an input pixel appear exactly LAT clocks after it is sampled. Sync signals are delayed with the same shift register, so there is no skew.
- Frame latch: a vs falling edge is in_vs 1 in the previous cycle and 0 now. On that clock, char_codes and blink_mask are copied into shadow registers. Rendering uses only the shadow registers, so mid-frame input changes never tear.
- Blink: on each vs falling edge the frame counter increments. When the counter reaches BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles. The update happens in the same clock as the latch.
- Stage 0 (registered):
  - dx = in_x - X0 and dy = in_y - Y0, evaluated unsigned 11-bit.
  - inbox = in_de & in_x >= X0 & in_x < X0 + NUM_CHARS*CHAR_W & in_y >= Y0 & in_y < Y0 + CHAR_H.
  - slot = dx / CHAR_W, col = dx % CHAR_W, row = dy.
- Stage 1: rom_addr <= code*(CHAR_W*CHAR_H/8) + row*(CHAR_W/8) + col/8. Bit index 7 - col%8 travels alongside in the pipeline, together with:
  - hide = code >= NUM_GLYPHS, or (blink_mask[slot] & blink_phase)
  - inbox and de
- When inbox = 0, rom_addr holds its previous value.
- Output stage:
  - de=0 → out_rgb=0.
  - de=1 & !inbox → out_rgb = 0.
  - inbox & hide → BG.
  - inbox & !hide → FG if rom_q[bit] = 1, else BG.
- Boundaries:
  - Last pixel of slot NUM_CHARS-1 is inside the box; x = X0 + NUM_CHARS*CHAR_W is outside.
  - A vs edge and a blink wrap in the same clock both apply.
  - A vs edge during reset is ignored.

Test Plan:
- Reset: hold rst 3 clocks with active in_de → out_de=0, out_hs=1, out_vs=1, out_rgb=0, rom_addr=0. After release, outputs follow the inputs delayed by exactly 4 clocks (ROM_LAT=2).
- Addressing: latched code 3, pixel x=X0+32*2+9, y=Y0+5 (slot 2, col 9, row 5) → rom_addr = 3*256 + 5*4 + 1 = 789 one clock after sampling. out_rgb = FG when ROM bit 6 of that byte is 1 (bit 7 - col%8 = 6), BG when it is 0.
- Box edges: pixels at x = X0-1 and X0 + 256 with de=1 → out_rgb = 0. Pixels at x = X0 and X0 + 255 → out_rgb taken from the glyph.
- Tearing: change char_codes from all-0 to all-5 mid-frame → rendering stays glyph 0 until the next vs falling edge, then switches to glyph 5 for the whole frame.
- Blink: blink_mask = 8'b0000_0011, BLINK_FRAMES = 2, 8 frames → slots 0-1 alternate 2 frames visible, 2 frames BG. Other slots stay constant throughout.
- Invalid code 12 → slot renders solid BG, while neighbouring slots render normally.

Source files
------------

// File: rtl/vga_text_line_renderer_if.sv
// Glyph ROM port of the text line renderer: the renderer drives the byte address,
// the ROM returns the glyph byte a fixed number of clocks later.
interface vga_text_line_renderer_if #(
  parameter int ROM_AW = 12
);
  logic [ROM_AW-1:0] rom_addr;
  logic [7:0]        rom_q;

  modport master (output rom_addr, input rom_q);
  modport slave  (input rom_addr, output rom_q);
endinterface

// File: rtl/vga_text_line_renderer.sv
// Renders NUM_CHARS glyphs from a shared ROM as one text line in a VGA raster,
// with frame-synchronous code latching and per-slot blinking.
module vga_text_line_renderer #(
  parameter int NUM_CHARS    = 8,
  parameter int CODE_W       = 4,
  parameter int NUM_GLYPHS   = 11,
  parameter int CHAR_W       = 32,
  parameter int CHAR_H       = 64,
  parameter int X0           = 64,
  parameter int Y0           = 208,
  parameter int ROM_LAT      = 2,
  parameter int BLINK_FRAMES = 15,
  parameter int RGB_W        = 8,
  parameter logic [RGB_W-1:0] FG = RGB_W'(8'hFF),
  parameter logic [RGB_W-1:0] BG = RGB_W'(8'h00)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_de,
  input  logic                        in_hs,
  input  logic                        in_vs,
  input  logic [9:0]                  in_x,
  input  logic [9:0]                  in_y,
  input  logic [NUM_CHARS*CODE_W-1:0] char_codes,
  input  logic [NUM_CHARS-1:0]        blink_mask,
  vga_text_line_renderer_if.master    rom,
  output logic                        out_de,
  output logic                        out_hs,
  output logic                        out_vs,
  output logic [RGB_W-1:0]            out_rgb
);

  localparam int GLYPH_BYTES = CHAR_W * CHAR_H / 8;
  localparam int ROW_BYTES   = CHAR_W / 8;
  localparam int ROM_AW      = CODE_W + $clog2(GLYPH_BYTES);
  localparam int SLOT_W      = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
  localparam int COL_W       = $clog2(CHAR_W);
  localparam int ROW_W       = (CHAR_H > 1) ? $clog2(CHAR_H) : 1;
  localparam int CNT_W       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [10:0]       X_LO        = 11'(X0);
  localparam logic [10:0]       X_HI        = 11'(X0 + NUM_CHARS * CHAR_W);
  localparam logic [10:0]       Y_LO        = 11'(Y0);
  localparam logic [10:0]       Y_HI        = 11'(Y0 + CHAR_H);
  localparam logic [10:0]       CHAR_W11    = 11'(CHAR_W);
  localparam logic [CODE_W:0]   GLYPH_LIMIT = (CODE_W + 1)'(NUM_GLYPHS);
  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(BLINK_FRAMES - 1);

  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic       inbox;
    logic       hide;
    logic [2:0] bit_idx;
  } side_t;

  localparam side_t SIDE_RST = '{de: 1'b0, hs: 1'b1, vs: 1'b1, inbox: 1'b0,
                                 hide: 1'b0, bit_idx: 3'd0};

  logic                        vs_prev_q, vs_prev_d;
  logic [NUM_CHARS*CODE_W-1:0] shadow_codes_q, shadow_codes_d;
  logic [NUM_CHARS-1:0]        shadow_mask_q, shadow_mask_d;
  logic [CNT_W-1:0]            frame_cnt_q, frame_cnt_d;
  logic                        blink_phase_q, blink_phase_d;

  logic                        s0_de_q, s0_de_d;
  logic                        s0_hs_q, s0_hs_d;
  logic                        s0_vs_q, s0_vs_d;
  logic                        s0_inbox_q, s0_inbox_d;
  logic [SLOT_W-1:0]           s0_slot_q, s0_slot_d;
  logic [COL_W-1:0]            s0_col_q, s0_col_d;
  logic [ROW_W-1:0]            s0_row_q, s0_row_d;

  logic [ROM_AW-1:0]           rom_addr_q, rom_addr_d;
  // side_q[0] is stage 1; the remaining ROM_LAT entries wait out the ROM read
  side_t                       side_q [ROM_LAT+1];
  side_t                       side_d [ROM_LAT+1];

  logic                        out_de_q, out_de_d;
  logic                        out_hs_q, out_hs_d;
  logic                        out_vs_q, out_vs_d;
  logic [RGB_W-1:0]            out_rgb_q, out_rgb_d;

  logic                        vs_fall;
  logic [10:0]                 dx, dy;
  logic [CODE_W-1:0]           code;
  side_t                       side_o;

  always_comb begin
    vs_fall        = vs_prev_q & ~in_vs;
    vs_prev_d      = in_vs;
    shadow_codes_d = shadow_codes_q;
    shadow_mask_d  = shadow_mask_q;
    frame_cnt_d    = frame_cnt_q;
    blink_phase_d  = blink_phase_q;
    if (vs_fall) begin
      shadow_codes_d = char_codes;
      shadow_mask_d  = blink_mask;
      if (frame_cnt_q == CNT_LAST) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end

    dx         = {1'b0, in_x} - X_LO;
    dy         = {1'b0, in_y} - Y_LO;
    s0_de_d    = in_de;
    s0_hs_d    = in_hs;
    s0_vs_d    = in_vs;
    s0_inbox_d = in_de & ({1'b0, in_x} >= X_LO) & ({1'b0, in_x} < X_HI)
                       & ({1'b0, in_y} >= Y_LO) & ({1'b0, in_y} < Y_HI);
    s0_slot_d  = s0_inbox_d ? SLOT_W'(dx / CHAR_W11) : '0;
    s0_col_d   = COL_W'(dx % CHAR_W11);
    s0_row_d   = ROW_W'(dy);

    code       = shadow_codes_q[s0_slot_q * CODE_W +: CODE_W];
    rom_addr_d = rom_addr_q;
    if (s0_inbox_q) begin
      rom_addr_d = ROM_AW'(code) * ROM_AW'(GLYPH_BYTES)
                 + ROM_AW'(s0_row_q) * ROM_AW'(ROW_BYTES)
                 + ROM_AW'(s0_col_q >> 3);
    end

    side_d[0] = '{de:      s0_de_q,
                  hs:      s0_hs_q,
                  vs:      s0_vs_q,
                  inbox:   s0_inbox_q,
                  hide:    ({1'b0, code} >= GLYPH_LIMIT)
                           | (shadow_mask_q[s0_slot_q] & blink_phase_q),
                  bit_idx: 3'd7 - s0_col_q[2:0]};
    for (int i = 1; i <= ROM_LAT; i++) begin
      side_d[i] = side_q[i-1];
    end

    side_o    = side_q[ROM_LAT];
    out_de_d  = side_o.de;
    out_hs_d  = side_o.hs;
    out_vs_d  = side_o.vs;
    out_rgb_d = '0;
    if (side_o.de && side_o.inbox) begin
      out_rgb_d = (side_o.hide || !rom.rom_q[side_o.bit_idx]) ? BG : FG;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_prev_q      <= 1'b1;
      shadow_codes_q <= '0;
      shadow_mask_q  <= '0;
      frame_cnt_q    <= '0;
      blink_phase_q  <= 1'b0;
      s0_de_q        <= 1'b0;
      s0_hs_q        <= 1'b1;
      s0_vs_q        <= 1'b1;
      s0_inbox_q     <= 1'b0;
      s0_slot_q      <= '0;
      s0_col_q       <= '0;
      s0_row_q       <= '0;
      rom_addr_q     <= '0;
      for (int i = 0; i <= ROM_LAT; i++) begin
        side_q[i] <= SIDE_RST;
      end
      out_de_q       <= 1'b0;
      out_hs_q       <= 1'b1;
      out_vs_q       <= 1'b1;
      out_rgb_q      <= '0;
    end else begin
      vs_prev_q      <= vs_prev_d;
      shadow_codes_q <= shadow_codes_d;
      shadow_mask_q  <= shadow_mask_d;
      frame_cnt_q    <= frame_cnt_d;
      blink_phase_q  <= blink_phase_d;
      s0_de_q        <= s0_de_d;
      s0_hs_q        <= s0_hs_d;
      s0_vs_q        <= s0_vs_d;
      s0_inbox_q     <= s0_inbox_d;
      s0_slot_q      <= s0_slot_d;
      s0_col_q       <= s0_col_d;
      s0_row_q       <= s0_row_d;
      rom_addr_q     <= rom_addr_d;
      side_q         <= side_d;
      out_de_q       <= out_de_d;
      out_hs_q       <= out_hs_d;
      out_vs_q       <= out_vs_d;
      out_rgb_q      <= out_rgb_d;
    end
  end

  assign rom.rom_addr = rom_addr_q;
  assign out_de       = out_de_q;
  assign out_hs       = out_hs_q;
  assign out_vs       = out_vs_q;
  assign out_rgb      = out_rgb_q;

endmodule
